// File: rtl/terc4_island_encoder_if.sv
// Packet header handshake between a packet source and the channel-0 island encoder.
interface terc4_island_encoder_if;
  logic        pkt_valid_in;
  logic [31:0] pkt_header_in;
  logic        pkt_ready_out;

  modport master (output pkt_valid_in, output pkt_header_in, input pkt_ready_out);
  modport slave  (input pkt_valid_in, input pkt_header_in, output pkt_ready_out);
endinterface

// File: rtl/terc4_island_encoder.sv
// HDMI TMDS channel-0 encoder: control symbols during blanking, TERC4 data islands
// (preamble, guard bands, packet header bits on TERC4 bit 2) when a packet is offered.
module terc4_island_encoder #(
  parameter int MAX_PACKETS = 2,
  parameter int MIN_CTRL    = 4
) (
  input  logic                         clk_1x_in,
  input  logic                         rst_n_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         island_en_in,
  terc4_island_encoder_if.slave        pkt,
  output logic [9:0]                   tmds_ch0_out,
  output logic                         preamble_out,
  output logic                         guard_out,
  output logic                         island_out
);

  localparam int          CW       = $clog2(MIN_CTRL + 1);
  localparam logic [CW-1:0] CTRL_SAT = CW'(MIN_CTRL);
  localparam logic [4:0]  PKT_LAST = 5'(MAX_PACKETS - 1);

  typedef enum logic [2:0] {
    S_CTRL,
    S_PREAMBLE,
    S_LEAD_GB,
    S_DATA,
    S_TRAIL_GB
  } state_t;

  state_t        state, state_n;
  logic [4:0]    cnt, cnt_n;
  logic [CW-1:0] ctrl_cnt, ctrl_n;
  logic [4:0]    pkt_cnt, pkt_cnt_n;
  logic [31:0]   shreg, shreg_n;
  logic          first_n;
  logic          ready;
  logic [9:0]    sym_n;
  logic          pre_n, guard_n, isl_n;

  function automatic logic [9:0] ctrl_code(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   ctrl_code = 10'b1101010100;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] idx);
    case (idx)
      4'd0:    terc4 = 10'b1010011100;
      4'd1:    terc4 = 10'b1001100011;
      4'd2:    terc4 = 10'b1011100100;
      4'd3:    terc4 = 10'b1011100010;
      4'd4:    terc4 = 10'b0101110001;
      4'd5:    terc4 = 10'b0100011110;
      4'd6:    terc4 = 10'b0110001110;
      4'd7:    terc4 = 10'b0100111100;
      4'd8:    terc4 = 10'b1011001100;
      4'd9:    terc4 = 10'b0100111001;
      4'd10:   terc4 = 10'b0110011100;
      4'd11:   terc4 = 10'b1011000110;
      4'd12:   terc4 = 10'b1010001110;
      4'd13:   terc4 = 10'b1001110001;
      4'd14:   terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  // Outputs are a function of the *next* state so that the registered symbol
  // lines up with the state it describes, using hsync/vsync sampled at this edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ctrl_n    = ctrl_cnt;
    pkt_cnt_n = pkt_cnt;
    shreg_n   = shreg;
    first_n   = 1'b0;
    ready     = 1'b0;

    case (state)
      S_CTRL: begin
        if (ctrl_cnt < CTRL_SAT) ctrl_n = ctrl_cnt + 1'b1;
        if (pkt.pkt_valid_in && island_en_in && ctrl_cnt >= CTRL_SAT) begin
          state_n = S_PREAMBLE;
          cnt_n   = '0;
        end
      end
      S_PREAMBLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == 5'd7) begin
          state_n = S_LEAD_GB;
          cnt_n   = '0;
          ctrl_n  = '0;
        end
      end
      S_LEAD_GB: begin
        cnt_n = cnt + 1'b1;
        if (cnt == 5'd1) begin
          ready     = rst_n_in;
          cnt_n     = '0;
          pkt_cnt_n = '0;
          if (pkt.pkt_valid_in) begin
            state_n = S_DATA;
            shreg_n = pkt.pkt_header_in;
            first_n = 1'b1;
          end else begin
            state_n = S_TRAIL_GB;
          end
        end
      end
      S_DATA: begin
        cnt_n   = cnt + 1'b1;
        shreg_n = {1'b0, shreg[31:1]};
        if (cnt == 5'd31) begin
          cnt_n = '0;
          if (pkt.pkt_valid_in && pkt_cnt < PKT_LAST) begin
            ready     = rst_n_in;
            shreg_n   = pkt.pkt_header_in;
            pkt_cnt_n = pkt_cnt + 1'b1;
          end else begin
            state_n = S_TRAIL_GB;
          end
        end
      end
      S_TRAIL_GB: begin
        cnt_n = cnt + 1'b1;
        if (cnt == 5'd1) begin
          state_n = S_CTRL;
          cnt_n   = '0;
        end
      end
      default: state_n = S_CTRL;
    endcase

    sym_n   = ctrl_code(vsync_in, hsync_in);
    pre_n   = 1'b0;
    guard_n = 1'b0;
    isl_n   = 1'b0;
    case (state_n)
      S_PREAMBLE: pre_n = 1'b1;
      S_LEAD_GB, S_TRAIL_GB: begin
        sym_n   = terc4({2'b11, vsync_in, hsync_in});
        guard_n = 1'b1;
        isl_n   = 1'b1;
      end
      S_DATA: begin
        sym_n = terc4({~first_n, shreg_n[0], vsync_in, hsync_in});
        isl_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign pkt.pkt_ready_out = ready;

  always_ff @(posedge clk_1x_in) begin
    if (!rst_n_in) begin
      state        <= S_CTRL;
      cnt          <= '0;
      ctrl_cnt     <= '0;
      pkt_cnt      <= '0;
      shreg        <= '0;
      tmds_ch0_out <= 10'b1101010100;
      preamble_out <= 1'b0;
      guard_out    <= 1'b0;
      island_out   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ctrl_cnt     <= ctrl_n;
      pkt_cnt      <= pkt_cnt_n;
      shreg        <= shreg_n;
      tmds_ch0_out <= sym_n;
      preamble_out <= pre_n;
      guard_out    <= guard_n;
      island_out   <= isl_n;
    end
  end

endmodule

// File: tb/tb_terc4_island_encoder.sv
// Randomized bench for terc4_island_encoder against a position-based island model.
module tb_terc4_island_encoder;
  localparam int MAX_PACKETS = 2;
  localparam int MIN_CTRL    = 4;

  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] CTRL_TAB [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  logic       clk_1x_in = 1'b0;
  logic       rst_n_in;
  logic       hsync_in, vsync_in, island_en_in;
  logic [9:0] tmds_ch0_out;
  logic       preamble_out, guard_out, island_out;

  terc4_island_encoder_if pkt_if ();

  terc4_island_encoder #(
    .MAX_PACKETS(MAX_PACKETS),
    .MIN_CTRL   (MIN_CTRL)
  ) dut (
    .clk_1x_in   (clk_1x_in),
    .rst_n_in    (rst_n_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .island_en_in(island_en_in),
    .pkt         (pkt_if),
    .tmds_ch0_out(tmds_ch0_out),
    .preamble_out(preamble_out),
    .guard_out   (guard_out),
    .island_out  (island_out)
  );

  always #5 clk_1x_in = ~clk_1x_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Source side
  bit          pending = 1'b0;
  logic [31:0] cur_hdr = '0;
  bit          hs = 1'b0, vs = 1'b0;

  // Model: island described by a single position counter from island start
  bit          m_isl = 1'b0;
  int          m_pos = 0;
  int          m_npk = 0;
  int          m_ctrl = 0;
  logic [31:0] m_hdr[$];
  logic [12:0] m_exp = {10'b1101010100, 3'b000};

  function automatic void model_edge(input bit xfer);
    int d, k, b;
    logic [3:0] idx;
    if (!rst_n_in) begin
      m_isl  = 1'b0;
      m_ctrl = 0;
      m_exp  = {CTRL_TAB[0], 3'b000};
      return;
    end
    if (!m_isl) begin
      if (pending && island_en_in && m_ctrl >= MIN_CTRL) begin
        m_isl = 1'b1;
        m_pos = 0;
        m_npk = 0;
        m_hdr.delete();
      end else if (m_ctrl < MIN_CTRL) begin
        m_ctrl++;
      end
    end else begin
      if (xfer) begin
        m_hdr.push_back(cur_hdr);
        m_npk++;
      end
      m_pos++;
      if (m_pos == 12 + 32 * m_npk) begin
        m_isl  = 1'b0;
        m_ctrl = 0;
      end
    end
    if (!m_isl)
      m_exp = {CTRL_TAB[{vs, hs}], 3'b000};
    else if (m_pos < 8)
      m_exp = {CTRL_TAB[{vs, hs}], 3'b100};
    else if (m_pos < 10 || m_pos >= 10 + 32 * m_npk)
      m_exp = {TERC4_TAB[{2'b11, vs, hs}], 3'b011};
    else begin
      d   = m_pos - 10;
      k   = d / 32;
      b   = d % 32;
      idx = {(d != 0), m_hdr[k][b], vs, hs};
      m_exp = {TERC4_TAB[idx], 3'b001};
    end
  endfunction

  task automatic run_cycle(input bit rst_v, input bit en_v, input bit offer);
    bit exp_rdy, dut_xfer;
    rst_n_in     = rst_v;
    island_en_in = en_v;
    hsync_in     = hs;
    vsync_in     = vs;
    if (!pending && offer) begin
      pending = 1'b1;
      cur_hdr = $urandom;
    end
    pkt_if.pkt_valid_in  = pending;
    pkt_if.pkt_header_in = cur_hdr;
    @(negedge clk_1x_in);
    exp_rdy = rst_v && m_isl && (m_pos == 9 + 32 * m_npk) &&
              (m_npk == 0 || (pending && m_npk < MAX_PACKETS));
    check_eq("pkt_ready", pkt_if.pkt_ready_out, exp_rdy);
    dut_xfer = pending && pkt_if.pkt_ready_out;
    @(posedge clk_1x_in);
    model_edge(pending && exp_rdy);
    if (dut_xfer) pending = 1'b0;
    #1;
    check_eq("tmds_flags", {tmds_ch0_out, preamble_out, guard_out, island_out}, m_exp);
  endtask

  task automatic random_phase(input int cycles, input int en_pct, input int offer_pct,
                              input int sync_pct, input int rst_pct, input bit sync_hold);
    for (int i = 0; i < cycles; i++) begin
      if (!sync_hold && $urandom_range(99, 0) < sync_pct) hs = ~hs;
      if (!sync_hold && $urandom_range(99, 0) < sync_pct) vs = ~vs;
      if (sync_hold && $urandom_range(99, 0) < sync_pct) hs = ~hs;
      run_cycle(!($urandom_range(999, 0) < rst_pct),
                $urandom_range(99, 0) < en_pct,
                $urandom_range(99, 0) < offer_pct);
    end
  endtask

  initial begin
    bit done;
    rst_n_in     = 1'b0;
    island_en_in = 1'b0;
    hsync_in     = 1'b0;
    vsync_in     = 1'b0;
    pkt_if.pkt_valid_in  = 1'b0;
    pkt_if.pkt_header_in = '0;
    @(posedge clk_1x_in);
    #1;

    // Reset with hs=1 and a packet waiting, then startup holdoff.
    hs = 1'b1;
    vs = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'b1, 1'b1);

    random_phase(3000, 70, 30, 10, 2, 1'b0);

    // Enable held low while a header waits, then released.
    for (int i = 0; i < 200; i++) run_cycle(1'b1, 1'b0, 1'b1);
    random_phase(300, 100, 100, 5, 0, 1'b0);

    // Both syncs high, hs toggling inside islands, enable flapping.
    hs = 1'b1;
    vs = 1'b1;
    random_phase(1500, 50, 40, 15, 0, 1'b1);

    // Reset deep inside a data phase; header must be taken again later.
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (m_isl && m_pos == 20) begin
        run_cycle(1'b0, 1'b1, 1'b1);
        done = 1'b1;
      end else begin
        run_cycle(1'b1, 1'b1, 1'b1);
      end
    end
    check_eq("reset_mid_data_reached", done, 1'b1);
    random_phase(400, 100, 60, 10, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
